// File: rtl/keypad_pkg.sv
// Shared key-code constants and debounce FSM state type for the keypad entry path.
package keypad_pkg;

  localparam int unsigned KEY_CODE_W = 8;
  localparam logic [KEY_CODE_W-1:0] KEY_NONE = 8'd10;
  localparam logic [KEY_CODE_W-1:0] KEY_MAX_DIGIT = 8'd9;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM; emits one accept per keystroke.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_CODE_W-1:0] numero,
  output logic                  accept,
  output logic [3:0]            code
);

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [KEY_CODE_W-1:0] sync_meta;
  logic [KEY_CODE_W-1:0] sync;
  logic [3:0]            candidate;
  logic [7:0]            cnt;
  key_state_e            state;
  logic                  is_digit;
  logic                  same_key;

  assign is_digit = (sync <= KEY_MAX_DIGIT);
  // Only meaningful when is_digit, so the upper code bits are already known zero.
  assign same_key = (sync[3:0] == candidate);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= KEY_NONE;
      sync      <= KEY_NONE;
    end else begin
      sync_meta <= numero;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      candidate <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_digit) begin
            candidate <= sync[3:0];
            cnt       <= 8'd1;
            state     <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!is_digit) begin
            state <= IDLE;
          end else if (same_key) begin
            if (cnt == LAST) state <= HELD;
            else             cnt   <= cnt + 8'd1;
          end else begin
            candidate <= sync[3:0];
            cnt       <= 8'd1;
          end
        end
        HELD: begin
          if (!is_digit) begin
            cnt   <= 8'd1;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (is_digit)         state <= HELD;
          else if (cnt == LAST) state <= IDLE;
          else                  cnt   <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded so the entry register can act on the same edge the FSM enters HELD.
  assign accept = (state == DEBOUNCE) && is_digit && same_key && (cnt == LAST);
  assign code   = candidate;

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry: debounced presses shifted into a BCD register with count/full/overflow.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned CNT_W        = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_CODE_W-1:0] numero,
  input  logic                  clear,
  output logic                  digit_valid,
  output logic [3:0]            digit,
  output logic [4*DIGITS-1:0]   valor,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIGITS);

  logic                accept;
  logic [3:0]          code;
  logic [4*DIGITS-1:0] valor_next;

  key_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .numero (numero),
    .accept (accept),
    .code   (code)
  );

  generate
    if (DIGITS == 1) begin : g_single
      assign valor_next = code;
    end else begin : g_shift
      assign valor_next = {valor[4*DIGITS-5:0], code};
    end
  endgenerate

  assign full = (count == FULL_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_valid <= 1'b0;
      digit       <= 4'd0;
      valor       <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      digit_valid <= accept;
      overflow    <= 1'b0;
      if (accept) digit <= code;
      // clear beats a coincident accept: the digit is reported but not stored.
      if (clear) begin
        valor <= '0;
        count <= '0;
      end else if (accept) begin
        if (!full) begin
          valor <= valor_next;
          count <= count + CNT_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed keystroke scenarios then random key traffic vs a run-length model.
module tb_keypad_entry;
  import keypad_pkg::*;

  localparam int unsigned D  = 4;
  localparam int unsigned S  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    numero;
  logic          clear;
  logic          digit_valid;
  logic [3:0]    digit;
  logic [4*D-1:0] valor;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;

  always #5 clk = ~clk;

  keypad_entry #(
    .DIGITS        (D),
    .STABLE_CYCLES (S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .numero      (numero),
    .clear       (clear),
    .digit_valid (digit_valid),
    .digit       (digit),
    .valor       (valor),
    .count       (count),
    .full        (full),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int last_acc_edge = -1;
  int n_acc = 0;
  int start;

  // Reference model: synchroniser delay line plus run lengths of digit / non-digit samples.
  logic [7:0] m_s1, m_s2;
  bit         armed;
  int         dig_run, nd_run, run_key;
  longint     m_valor;
  int         m_count;
  logic       m_dv, m_ov;
  logic [3:0] m_digit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h edge=%0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    m_s1 = KEY_NONE; m_s2 = KEY_NONE;
    armed = 1; dig_run = 0; nd_run = 0; run_key = -1;
    m_valor = 0; m_count = 0; m_dv = 0; m_ov = 0; m_digit = 0;
  endtask

  task automatic model_edge(input logic [7:0] num, input logic c);
    logic [7:0] obs;
    obs = m_s2; m_s2 = m_s1; m_s1 = num;
    m_dv = 0; m_ov = 0;
    if (obs <= 8'd9) begin
      nd_run = 0;
      if (int'(obs) == run_key) dig_run++;
      else begin run_key = int'(obs); dig_run = 1; end
      // A press is a run of S identical digit samples that starts while released.
      if (armed && dig_run == S) begin
        armed = 0; m_dv = 1; m_digit = obs[3:0];
        if (!c && m_count < D) begin
          m_valor = (m_valor * 16 + longint'(obs[3:0])) % (longint'(1) << (4 * D));
          m_count++;
        end else if (!c) m_ov = 1;
      end
    end else begin
      run_key = -1; dig_run = 0; nd_run++;
      if (nd_run >= S) armed = 1;
    end
    if (c) begin m_valor = 0; m_count = 0; end
  endtask

  task automatic check_all();
    chk("digit_valid", 32'(digit_valid), 32'(m_dv));
    chk("digit", 32'(digit), 32'(m_digit));
    chk("valor", 32'(valor), 32'(m_valor));
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == D));
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic step(input logic [7:0] n, input logic c);
    numero = n; clear = c;
    @(posedge clk); #1;
    edge_no++;
    model_edge(n, c);
    if (digit_valid === 1'b1) begin n_acc++; last_acc_edge = edge_no; end
    check_all();
  endtask

  task automatic hold(input logic [7:0] n, input int k);
    repeat (k) step(n, 1'b0);
  endtask

  task automatic press(input logic [7:0] d);
    hold(d, S + 2);
    hold(KEY_NONE, S + 3);
  endtask

  initial begin
    reset = 1'b1; numero = KEY_NONE; clear = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;

    // Single press; the first edge after the change is edge 0, accept lands on edge S+1.
    n_acc = 0; start = edge_no;
    hold(8'd5, 20);
    chk("press_latency", 32'(last_acc_edge - (start + 1)), S + 1);
    chk("single_press", 32'(n_acc), 1);
    hold(KEY_NONE, S + 3);
    chk("valor_5", 32'(valor), 32'h0005);

    // Fill the register, then overflow.
    step(KEY_NONE, 1'b1);
    press(8'd1); press(8'd2); press(8'd3); press(8'd4);
    chk("valor_1234", 32'(valor), 32'h1234);
    chk("full_at_4", 32'(full), 1);
    hold(8'd7, S + 2);
    chk("ovf_pulse", 32'(overflow), 1);
    hold(KEY_NONE, S + 3);
    chk("valor_kept", 32'(valor), 32'h1234);

    // Bounce on press.
    step(KEY_NONE, 1'b1);
    n_acc = 0;
    step(8'd3, 1'b0); step(KEY_NONE, 1'b0); step(8'd3, 1'b0); step(KEY_NONE, 1'b0);
    start = edge_no;
    hold(8'd3, 10);
    hold(KEY_NONE, S + 3);
    chk("bounce_once", 32'(n_acc), 1);
    chk("bounce_latency", 32'(last_acc_edge - (start + 1)), S + 1);
    chk("bounce_digit", 32'(digit), 3);

    // Key change while held.
    n_acc = 0;
    hold(8'd6, S + 3); hold(8'd8, 2 * S + 4); hold(KEY_NONE, S + 3);
    chk("change_once", 32'(n_acc), 1);
    chk("change_digit", 32'(digit), 6);
    press(8'd8);
    chk("second_press", 32'(digit), 8);

    // Illegal codes act as no key.
    n_acc = 0;
    hold(8'd11, 20); hold(8'd200, 20);
    chk("illegal_none", 32'(n_acc), 0);
    hold(KEY_NONE, 3); press(8'd9);
    chk("nine_ok", 32'(n_acc), 1);
    chk("nine_digit", 32'(digit), 9);

    // clear coincident with an accept.
    step(KEY_NONE, 1'b1);
    press(8'd1); press(8'd2);
    chk("valor_12", 32'(valor), 32'h0012);
    hold(8'd4, S + 1);
    step(8'd4, 1'b1);
    chk("clr_acc_dv", 32'(digit_valid), 1);
    chk("clr_acc_valor", 32'(valor), 0);
    chk("clr_acc_count", 32'(count), 0);
    chk("clr_acc_digit", 32'(digit), 4);
    hold(KEY_NONE, S + 3);

    // Async reset mid-debounce.
    press(8'd7);
    hold(8'd2, 4);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_valor", 32'(valor), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    n_acc = 0; start = edge_no;
    hold(8'd2, S + 3);
    chk("rst_latency", 32'(last_acc_edge - (start + 1)), S + 1);
    chk("rst_once", 32'(n_acc), 1);
    hold(KEY_NONE, S + 3);

    // Random key traffic.
    repeat (300) begin
      int r;
      int len;
      logic [7:0] k;
      r = $urandom_range(0, 99);
      if (r < 70) k = 8'($urandom_range(0, 9));
      else if (r < 85) k = KEY_NONE;
      else k = 8'($urandom_range(11, 255));
      len = $urandom_range(1, 2 * S + 3);
      repeat (len) step(k, ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
